// File: rtl/ram_dump_tx.sv
// ram_dump_tx: on a trigger, reads the whole RAM through a synchronous read port
// and streams it out as UART 8N1 frames: header, RAM bytes in address order, checksum.
`default_nettype none

module ram_dump_tx #(
    parameter int         CLKS_PER_BIT = 104,
    parameter int         ADDR_WIDTH   = 4,
    parameter logic [7:0] HEADER_BYTE  = 8'hA5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd_en,
    input  logic [7:0]            mem_data,
    output logic                  tx,
    output logic                  busy,
    output logic                  done
);

    localparam int            CW         = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] C_CNT_MAX  = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    C_STOP_BIT = 4'd9;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_HEADER   = 3'd1,
        S_DATA     = 3'd2,
        S_CHECKSUM = 3'd3,
        S_FINISH   = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [CW-1:0]         r_clk_cnt;
    logic [3:0]            r_bit_idx;
    logic [7:0]            r_shift;
    logic [7:0]            r_hold;
    logic [7:0]            r_chk;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_armed;
    logic                  r_rd_d;
    logic                  r_last_read;
    logic                  r_final_byte;

    logic w_framing;
    logic w_bit_end;
    logic w_frame_end;
    logic w_accept;
    logic w_rd_en;

    assign w_framing   = (r_state == S_HEADER) || (r_state == S_DATA) || (r_state == S_CHECKSUM);
    assign w_bit_end   = w_framing && (r_clk_cnt == C_CNT_MAX);
    assign w_frame_end = w_bit_end && (r_bit_idx == C_STOP_BIT);
    assign w_accept    = (r_state == S_IDLE) && start && r_armed;
    // Prefetch the next data byte during the first cycle of each start bit.
    assign w_rd_en     = (r_clk_cnt == '0) && (r_bit_idx == 4'd0) &&
                         ((r_state == S_HEADER) || ((r_state == S_DATA) && !r_last_read));
    assign mem_addr    = r_addr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        tx        = 1'b1;
        busy      = w_framing;
        done      = 1'b0;
        mem_rd_en = w_rd_en;
        if (w_framing) begin
            if (r_bit_idx == 4'd0) begin
                tx = 1'b0;
            end else if (r_bit_idx != C_STOP_BIT) begin
                tx = r_shift[0];
            end
        end
        case (r_state)
            S_IDLE:     if (w_accept) w_next = S_HEADER;
            S_HEADER:   if (w_frame_end) w_next = S_DATA;
            S_DATA:     if (w_frame_end && r_final_byte) w_next = S_CHECKSUM;
            S_CHECKSUM: if (w_frame_end) w_next = S_FINISH;
            S_FINISH: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default:    w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clk_cnt    <= '0;
            r_bit_idx    <= 4'd0;
            r_shift      <= 8'd0;
            r_hold       <= 8'd0;
            r_chk        <= 8'd0;
            r_addr       <= '0;
            r_armed      <= 1'b1;
            r_rd_d       <= 1'b0;
            r_last_read  <= 1'b0;
            r_final_byte <= 1'b0;
        end else begin
            r_rd_d <= w_rd_en;
            if ((r_state == S_IDLE) && !start) begin
                r_armed <= 1'b1;
            end
            if (w_accept) begin
                r_armed      <= 1'b0;
                r_shift      <= HEADER_BYTE;
                r_chk        <= 8'd0;
                r_addr       <= '0;
                r_last_read  <= 1'b0;
                r_final_byte <= 1'b0;
                r_clk_cnt    <= '0;
                r_bit_idx    <= 4'd0;
            end
            if (w_rd_en) begin
                r_addr <= r_addr + ADDR_WIDTH'(1);
                if (r_addr == '1) begin
                    r_last_read <= 1'b1;
                end
            end
            if (r_rd_d) begin
                r_hold <= mem_data;
                r_chk  <= r_chk + mem_data;
            end
            if (w_framing) begin
                if (w_bit_end) begin
                    r_clk_cnt <= '0;
                    if (w_frame_end) begin
                        r_bit_idx <= 4'd0;
                        // The byte loaded after the wrap read is the last data byte.
                        if ((r_state == S_HEADER) || ((r_state == S_DATA) && !r_final_byte)) begin
                            r_shift      <= r_hold;
                            r_final_byte <= r_last_read;
                        end else if (r_state == S_DATA) begin
                            r_shift <= r_chk;
                        end
                    end else begin
                        r_bit_idx <= r_bit_idx + 4'd1;
                        if (r_bit_idx != 4'd0) begin
                            r_shift <= r_shift >> 1;
                        end
                    end
                end else begin
                    r_clk_cnt <= r_clk_cnt + CW'(1);
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ram_dump_tx.sv
// tb_ram_dump_tx: directed bench that decodes the tx stream and compares frames
// against a behavioural RAM and hand-computed checksums.
`default_nettype none
`timescale 1ns/1ps

module tb_ram_dump_tx;

    localparam int CPB   = 4;
    localparam int AW    = 4;
    localparam int NB    = 16;
    localparam int FRAME = 10 * CPB;

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] mem_addr;
    logic          mem_rd_en;
    logic [7:0]    mem_data = 8'd0;
    logic          tx;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    ram_dump_tx #(
        .CLKS_PER_BIT (CPB),
        .ADDR_WIDTH   (AW),
        .HEADER_BYTE  (8'hA5)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mem_addr  (mem_addr),
        .mem_rd_en (mem_rd_en),
        .mem_data  (mem_data),
        .tx        (tx),
        .busy      (busy),
        .done      (done)
    );

    logic [7:0] ram [NB];
    always @(posedge clk) if (mem_rd_en) mem_data <= ram[mem_addr];

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Stream monitor: UART decoder plus pulse counters, sampled on the falling edge.
    logic [7:0] rx_q [$];
    logic [7:0] rx_byte;
    logic       rx_act    = 1'b0;
    logic       bit_val   = 1'b0;
    int         rx_idx    = 0;
    int         frame_err = 0;
    int         done_cnt  = 0;
    int         rd_cnt    = 0;
    int         done_cyc  = 0;
    int         first_cyc = 0;
    bit         got_first = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            rx_act = 1'b0;
        end else begin
            if (mem_rd_en) rd_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (!rx_act) begin
                if (tx == 1'b0) begin
                    rx_act  = 1'b1;
                    rx_idx  = 0;
                    bit_val = 1'b0;
                    rx_byte = 8'd0;
                    if (!got_first) begin
                        got_first = 1'b1;
                        first_cyc = cyc;
                    end
                end
            end else begin
                rx_idx++;
                if (rx_idx % CPB == 0) bit_val = tx;
                else if (tx != bit_val) frame_err++;
                if (rx_idx % CPB == CPB / 2) begin
                    if (rx_idx / CPB >= 1 && rx_idx / CPB <= 8) rx_byte[rx_idx / CPB - 1] = tx;
                    if (rx_idx / CPB == 9 && tx != 1'b1) frame_err++;
                end
                if (rx_idx == FRAME - 1) begin
                    rx_q.push_back(rx_byte);
                    rx_act = 1'b0;
                end
            end
        end
    end

    task automatic clear_mon();
        rx_q.delete();
        frame_err = 0;
        done_cnt  = 0;
        rd_cnt    = 0;
        got_first = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk); #1;
            if (done_cnt > 0) seen = 1'b1;
        end
        check({tag, "_done_seen"}, seen, 1'b1);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_frame(input string tag, input logic [7:0] exp_chk);
        repeat (3) @(negedge clk);
        #1;
        check({tag, "_nbytes"}, rx_q.size(), NB + 2);
        if (rx_q.size() == NB + 2) begin
            check({tag, "_header"}, rx_q[0], 8'hA5);
            for (int i = 0; i < NB; i++) check($sformatf("%s_data%0d", tag, i), rx_q[i + 1], ram[i]);
            check({tag, "_chk"}, rx_q[NB + 1], exp_chk);
        end
        check({tag, "_framing"}, frame_err, 0);
        check({tag, "_rd_cnt"}, rd_cnt, NB);
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_idle_tx"}, tx, 1'b1);
        check({tag, "_idle_busy"}, busy, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < NB; i++) ram[i] = 8'h00;
        repeat (3) @(negedge clk);
        #1;
        check("rst_tx", tx, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_addr", mem_addr, 0);
        check("rst_rd_en", mem_rd_en, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // All-zero RAM, latency and dump length.
        clear_mon();
        start = 1'b1;
        @(negedge clk); #1;
        check("lat_busy", busy, 1'b1);
        check("lat_tx", tx, 1'b0);
        start = 1'b0;
        wait_done("zero");
        check("zero_done_time", done_cyc - first_cyc, (NB + 2) * FRAME);
        check("zero_done_busy", busy, 1'b0);
        @(negedge clk); #1;
        check("zero_done_width", done, 1'b0);
        check_frame("zero", 8'h00);

        // Counting pattern.
        for (int i = 0; i < NB; i++) ram[i] = 8'(i + 1);
        clear_mon();
        pulse_start();
        wait_done("count");
        check_frame("count", 8'h88);

        // All-ones RAM: checksum wraps.
        for (int i = 0; i < NB; i++) ram[i] = 8'hFF;
        clear_mon();
        pulse_start();
        wait_done("ones");
        check_frame("ones", 8'hF0);

        // Held trigger gives one dump; a one-cycle drop re-arms.
        for (int i = 0; i < NB; i++) ram[i] = 8'(i + 1);
        clear_mon();
        @(negedge clk);
        start = 1'b1;
        repeat (2000) @(negedge clk);
        check_frame("held", 8'h88);
        start = 1'b0;
        clear_mon();
        @(negedge clk);
        start = 1'b1;
        wait_done("rearm");
        start = 1'b0;
        check_frame("rearm", 8'h88);

        // Reset in the middle of data byte 5.
        clear_mon();
        pulse_start();
        for (int i = 0; i < 2000 && rx_q.size() < 6; i++) begin
            @(negedge clk); #1;
        end
        check("mid_reached", rx_q.size(), 6);
        repeat (17) @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid_tx", tx, 1'b1);
        check("mid_busy", busy, 1'b0);
        check("mid_rd_en", mem_rd_en, 1'b0);
        check("mid_done", done, 1'b0);
        repeat (5) @(negedge clk);
        reset = 1'b0;
        repeat (50) @(negedge clk);
        #1;
        check("mid_no_done", done_cnt, 0);
        check("mid_idle_busy", busy, 1'b0);
        clear_mon();
        pulse_start();
        wait_done("after_rst");
        check_frame("after_rst", 8'h88);

        // Start toggled while busy has no effect.
        clear_mon();
        pulse_start();
        repeat (100) @(negedge clk);
        start = 1'b1;
        repeat (30) @(negedge clk);
        start = 1'b0;
        repeat (200) @(negedge clk);
        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        wait_done("busy_tog");
        check_frame("busy_tog", 8'h88);

        // Reset released with start high starts a dump on the next edge.
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        repeat (3) @(negedge clk);
        clear_mon();
        reset = 1'b0;
        @(negedge clk); #1;
        check("rst_start_busy", busy, 1'b1);
        start = 1'b0;
        wait_done("rst_start");
        check_frame("rst_start", 8'h88);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
